// File: rtl/spart_driver.sv
// Bring-up bus initiator for spart: programs the 16-bit baud divisor chosen by br_cfg, then echoes every received byte.
// Optional DRV_UPCASE_EN: lowercase ASCII ('a'..'z') is echoed as uppercase; last_char always keeps the raw byte.
module spart_driver #(
    parameter logic [15:0] DIV_0 = 16'd1301,
    parameter logic [15:0] DIV_1 = 16'd650,
    parameter logic [15:0] DIV_2 = 16'd325,
    parameter logic [15:0] DIV_3 = 16'd162
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] last_char
);

    localparam logic [2:0] ST_RST     = 3'd0;
    localparam logic [2:0] ST_WR_LO   = 3'd1;
    localparam logic [2:0] ST_WR_HI   = 3'd2;
    localparam logic [2:0] ST_WAIT_RX = 3'd3;
    localparam logic [2:0] ST_READ    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;
    localparam logic [2:0] ST_WRITE   = 3'd6;
    localparam logic [2:0] ST_GAP     = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  cfg_q, cfg_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  last_q, last_d;
    logic [1:0]  div_sel;
    logic [15:0] div_val;
    logic [7:0]  tx_byte;
    logic [7:0]  bus_dat;

    // WR_LO uses the live switches; WR_HI reuses the selection captured in WR_LO
    assign div_sel = (state_q == ST_WR_LO) ? br_cfg : sel_q;

    always_comb begin
        case (div_sel)
            2'b00:   div_val = DIV_0;
            2'b01:   div_val = DIV_1;
            2'b10:   div_val = DIV_2;
            default: div_val = DIV_3;
        endcase
    end

`ifdef DRV_UPCASE_EN
    assign tx_byte = (rx_q >= 8'h61 && rx_q <= 8'h7A) ? (rx_q - 8'h20) : rx_q;
`else
    assign tx_byte = rx_q;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cfg_d   = cfg_q;
        rx_d    = rx_q;
        last_d  = last_q;
        iocs    = 1'b0;
        iorw    = 1'b1;
        ioaddr  = 2'b01;
        bus_dat = 8'h00;
        case (state_q)
            ST_RST: begin
                state_d = ST_WR_LO;
            end
            ST_WR_LO: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                ioaddr  = 2'b10;
                bus_dat = div_val[7:0];
                sel_d   = br_cfg;
                state_d = ST_WR_HI;
            end
            ST_WR_HI: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                ioaddr  = 2'b11;
                bus_dat = div_val[15:8];
                cfg_d   = br_cfg;
                state_d = ST_WAIT_RX;
            end
            ST_WAIT_RX: begin
                // a switch change wins over rda; rda stays pending and is read after reprogramming
                if (br_cfg != cfg_q) begin
                    state_d = ST_WR_LO;
                end else if (rda) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                iocs    = 1'b1;
                iorw    = 1'b1;
                ioaddr  = 2'b00;
                rx_d    = databus;
                last_d  = databus;
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tbr) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                ioaddr  = 2'b00;
                bus_dat = tx_byte;
                state_d = ST_GAP;
            end
            default: begin
                state_d = ST_WAIT_RX;
            end
        endcase
    end

    assign databus   = (iocs && !iorw) ? bus_dat : 8'hzz;
    assign last_char = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RST;
            sel_q   <= 2'b00;
            cfg_q   <= 2'b00;
            rx_q    <= 8'h00;
            last_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cfg_q   <= cfg_d;
            rx_q    <= rx_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: directed bring-up/latency steps, then randomized echo traffic against an access-sequence model.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] last_char;
    logic [7:0] rd_dat;

    int checks   = 0;
    int failures = 0;

    // bus access record: {iorw, ioaddr, data}
    logic [10:0] acc_q[$];
    logic [10:0] exp_q[$];
    int          div_tab[4] = '{1301, 650, 325, 162};
    logic [1:0]  model_cfg;

    spart_driver dut (
        .clk       (clk),
        .rst       (rst),
        .br_cfg    (br_cfg),
        .rda       (rda),
        .tbr       (tbr),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus),
        .last_char (last_char)
    );

    always #5 clk = ~clk;

    // the bench plays spart: it drives the bus only while a read is strobed
    assign databus = (iocs === 1'b1 && iorw === 1'b1) ? rd_dat : 8'hzz;

    function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef DRV_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'd32;
`endif
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        if (iocs === 1'b1) begin
            acc_q.push_back({iorw, ioaddr, databus});
            if (iorw === 1'b0) chk("wr_bus_driven", {31'd0, $isunknown(databus)}, 32'd0);
        end else begin
            chk("idle_bus", {21'd0, iorw, ioaddr, databus}, {21'd0, 1'b1, 2'b01, 8'hzz});
        end
    endtask

    task automatic push_reprog(input logic [1:0] c);
        exp_q.push_back({1'b0, 2'b10, 8'(div_tab[c] % 256)});
        exp_q.push_back({1'b0, 2'b11, 8'(div_tab[c] / 256)});
    endtask

    task automatic wait_cmp(input string tag, input int bound);
        int n = 0;
        while (acc_q.size() < exp_q.size() && n < bound) begin
            step();
            n++;
        end
        chk({tag, "_count"}, {31'd0, acc_q.size() >= exp_q.size()}, 32'd1);
        while (exp_q.size() > 0 && acc_q.size() > 0)
            chk(tag, acc_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
    endtask

    task automatic echo(input string tag, input logic [7:0] b, input logic [1:0] cfg_rx,
                        input int rx_dly, input int tx_dly, input logic [1:0] cfg_tx);
        repeat (rx_dly) step();
        if (cfg_rx != model_cfg) begin
            push_reprog(cfg_rx);
            model_cfg = cfg_rx;
        end
        br_cfg = cfg_rx;
        rd_dat = b;
        rda    = 1'b1;
        exp_q.push_back({1'b1, 2'b00, b});
        wait_cmp({tag, "_rd"}, 30);
        rda = 1'b0;
        step();
        chk({tag, "_last"}, last_char, b);
        br_cfg = cfg_tx;
        repeat (tx_dly) step();
        chk({tag, "_hold"}, acc_q.size(), 0);
        tbr = 1'b1;
        exp_q.push_back({1'b0, 2'b00, echo_of(b)});
        wait_cmp({tag, "_wr"}, 10);
        tbr = 1'b0;
        if (cfg_tx != model_cfg) begin
            push_reprog(cfg_tx);
            model_cfg = cfg_tx;
        end
    endtask

    initial begin
        rst = 1'b1; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; rd_dat = 8'h00;
        model_cfg = 2'b01;
        step();
        step();
        chk("rst_bus", {iocs, iorw, ioaddr}, {1'b0, 1'b1, 2'b01});
        chk("rst_last", last_char, 8'h00);
        rst = 1'b0;
        acc_q.delete();

        step();
        chk("div_lo", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b10, 8'h8A});
        step();
        chk("div_hi", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b11, 8'h02});
        step();
        chk("post_div_idle", iocs, 1'b0);
        acc_q.delete();

        rd_dat = 8'h41;
        rda    = 1'b1;
        step();
        chk("rd_strobe", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b1, 2'b00, 8'h41});
        rda = 1'b0;
        acc_q.delete();
        step();
        chk("rd_last", last_char, 8'h41);
        repeat (49) step();
        chk("tbr_hold", acc_q.size(), 0);
        tbr = 1'b1;
        step();
        chk("wr_echo", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b00, echo_of(8'h41)});
        tbr = 1'b0;
        step();
        chk("gap_idle", iocs, 1'b0);
        acc_q.delete();

        echo("upc_62", 8'h62, 2'b01, 2, 0, 2'b01);
        echo("upc_7b", 8'h7B, 2'b01, 1, 3, 2'b01);
        echo("upc_61", 8'h61, 2'b01, 0, 1, 2'b01);
        echo("upc_7a", 8'h7A, 2'b01, 3, 0, 2'b01);
        echo("upc_60", 8'h60, 2'b01, 2, 2, 2'b01);

        // switch change lands in the same cycle as rda while waiting for a byte
        echo("cfg_pri", 8'h55, 2'b11, 2, 1, 2'b11);

        rd_dat = 8'h99;
        rda    = 1'b1;
        exp_q.push_back({1'b1, 2'b00, 8'h99});
        wait_cmp("rst_rd", 20);
        rda = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rst_tx_bus", {iocs, iorw, ioaddr}, {1'b0, 1'b1, 2'b01});
        chk("rst_tx_last", last_char, 8'h00);
        rst = 1'b0;
        acc_q.delete();
        exp_q.delete();
        tbr = 1'b1;
        push_reprog(br_cfg);
        model_cfg = br_cfg;
        repeat (12) step();
        wait_cmp("rst_reprog", 5);
        chk("rst_no_echo", acc_q.size(), 0);
        tbr = 1'b0;

        for (int i = 0; i < 16; i++) begin
            logic [1:0] c_rx;
            logic [1:0] c_tx;
            c_rx = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : model_cfg;
            c_tx = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : c_rx;
            echo("rand", 8'($urandom), c_rx, $urandom_range(6, 9), $urandom_range(0, 5), c_tx);
        end

        repeat (8) step();
        wait_cmp("final_flush", 5);
        chk("final_acc", acc_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
